// File: rtl/cordic_engine.sv
// Pipelined CORDIC engine: per-sample vectoring or rotation mode, one quadrant
// pre-rotation, STAGES micro-rotations and a stallable output register.
module cordic_engine #(
    parameter int DATA_W  = 16,
    parameter int ANGLE_W = 16,
    parameter int STAGES  = 14
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic                      s_mode,
    input  logic signed [DATA_W-1:0]  s_x,
    input  logic signed [DATA_W-1:0]  s_y,
    input  logic signed [ANGLE_W-1:0] s_z,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic signed [DATA_W+1:0]  m_x,
    output logic signed [DATA_W+1:0]  m_y,
    output logic signed [ANGLE_W-1:0] m_z,
    output logic                      m_mode
);

    localparam int XW = DATA_W + 2;
    localparam logic signed [ANGLE_W-1:0] QUARTER = ANGLE_W'(1 << (ANGLE_W - 2));
    localparam real PI = 3.14159265358979323846;

    if (STAGES < 4 || STAGES > ANGLE_W - 1) begin : g_bad_stages
        $error("cordic_engine: STAGES must lie in 4..ANGLE_W-1");
    end

    // atan(2^-i) in binary-angle LSBs; atan(1) is exact, the rest use a fast-converging series.
    function automatic int atan_lsb(input int i);
        real x, term, sum, scale;
        x = 1.0;
        for (int k = 0; k < i; k++) x = x / 2.0;
        if (i == 0) begin
            sum = PI / 4.0;
        end else begin
            sum  = 0.0;
            term = x;
            for (int k = 0; k < 24; k++) begin
                if (k % 2 == 0) sum = sum + term / real'(2 * k + 1);
                else            sum = sum - term / real'(2 * k + 1);
                term = term * x * x;
            end
        end
        scale = 1.0;
        for (int k = 0; k < ANGLE_W; k++) scale = scale * 2.0;
        return $rtoi(sum * scale / (2.0 * PI) + 0.5);
    endfunction

    typedef struct packed {
        logic                      mode;
        logic signed [XW-1:0]      x;
        logic signed [XW-1:0]      y;
        logic signed [ANGLE_W-1:0] z;
    } sample_t;

    logic                      en;
    logic [STAGES:0]           vld_q;
    sample_t                   stg_q [STAGES+1];
    sample_t                   stg_d [STAGES+1];
    sample_t                   pre_d;
    logic signed [XW-1:0]      in_x, in_y;

    logic                      m_valid_q;
    logic signed [XW-1:0]      m_x_q, m_y_q;
    logic signed [ANGLE_W-1:0] m_z_q;
    logic                      m_mode_q;

    assign en      = !m_valid_q || m_ready;
    assign s_ready = en;

    assign in_x = {{2{s_x[DATA_W-1]}}, s_x};
    assign in_y = {{2{s_y[DATA_W-1]}}, s_y};

    always_comb begin
        pre_d.mode = s_mode;
        // Vectoring with y>=0 or rotation with z<0: turn by -90 deg and book +90 deg into z.
        if (s_mode ? s_z[ANGLE_W-1] : !in_y[XW-1]) begin
            pre_d.x = in_y;
            pre_d.y = -in_x;
            pre_d.z = s_z + QUARTER;
        end else begin
            pre_d.x = -in_y;
            pre_d.y = in_x;
            pre_d.z = s_z - QUARTER;
        end
    end

    assign stg_d[0] = pre_d;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam logic signed [ANGLE_W-1:0] ATAN_I = ANGLE_W'(atan_lsb(i));
        sample_t              cur, nxt;
        logic signed [XW-1:0] x_sh, y_sh;
        logic                 d_pos;

        assign cur   = stg_q[i];
        assign x_sh  = $signed(cur.x) >>> i;
        assign y_sh  = $signed(cur.y) >>> i;
        assign d_pos = cur.mode ? !cur.z[ANGLE_W-1] : cur.y[XW-1];

        always_comb begin
            nxt = cur;
            if (d_pos) begin
                nxt.x = cur.x - y_sh;
                nxt.y = cur.y + x_sh;
                nxt.z = cur.z - ATAN_I;
            end else begin
                nxt.x = cur.x + y_sh;
                nxt.y = cur.y - x_sh;
                nxt.z = cur.z + ATAN_I;
            end
        end

        assign stg_d[i+1] = nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_q <= '0;
        else if (en) vld_q <= {vld_q[STAGES-1:0], s_valid};
    end

    // NOTE: the stage data registers carry no reset; the cleared valid bits already make stale contents harmless.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i <= STAGES; i++) stg_q[i] <= stg_d[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_x_q     <= '0;
            m_y_q     <= '0;
            m_z_q     <= '0;
            m_mode_q  <= 1'b0;
        end else if (en) begin
            m_valid_q <= vld_q[STAGES];
            m_x_q     <= stg_q[STAGES].x;
            m_y_q     <= stg_q[STAGES].y;
            m_z_q     <= stg_q[STAGES].z;
            m_mode_q  <= stg_q[STAGES].mode;
        end
    end

    assign m_valid = m_valid_q;
    assign m_x     = m_x_q;
    assign m_y     = m_y_q;
    assign m_z     = m_z_q;
    assign m_mode  = m_mode_q;

endmodule

// File: tb/tb_cordic_engine.sv
// Self-checking bench for cordic_engine: directed accuracy cases against ideal
// trigonometry plus a randomized stalled stream against an integer CORDIC model.
module tb_cordic_engine;

    localparam int NSTG = 14;

    logic               clk;
    logic               reset;
    logic               s_valid;
    logic               s_ready;
    logic               s_mode;
    logic signed [15:0] s_x, s_y, s_z;
    logic               m_valid;
    logic               m_ready;
    logic signed [17:0] m_x, m_y;
    logic signed [15:0] m_z;
    logic               m_mode;

    int n_checks = 0;
    int n_pass   = 0;
    int atan_tab [NSTG];

    typedef struct {
        int x;
        int y;
        int z;
        bit mode;
    } exp_t;

    cordic_engine #(.DATA_W(16), .ANGLE_W(16), .STAGES(NSTG)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_mode  (s_mode),
        .s_x     (s_x),
        .s_y     (s_y),
        .s_z     (s_z),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_x     (m_x),
        .m_y     (m_y),
        .m_z     (m_z),
        .m_mode  (m_mode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int wrapn(input int v, input int w);
        int m;
        m = v & ((1 << w) - 1);
        if (m >= (1 << (w - 1))) m = m - (1 << w);
        return m;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Textbook CORDIC on integers with 18-bit x/y and 16-bit wrapping angle.
    function automatic void model(input bit mode, input int x0, input int y0, input int z0,
                                  output int xo, output int yo, output int zo);
        int x, y, z, t;
        bit d_pos;
        if ((!mode && y0 >= 0) || (mode && z0 < 0)) begin
            x = y0; y = -x0; z = z0 + 16384;
        end else begin
            x = -y0; y = x0; z = z0 - 16384;
        end
        x = wrapn(x, 18); y = wrapn(y, 18); z = wrapn(z, 16);
        for (int i = 0; i < NSTG; i++) begin
            d_pos = mode ? (z >= 0) : (y < 0);
            if (d_pos) begin
                t = x - (y >>> i); y = y + (x >>> i); x = t; z = z - atan_tab[i];
            end else begin
                t = x + (y >>> i); y = y - (x >>> i); x = t; z = z + atan_tab[i];
            end
            x = wrapn(x, 18); y = wrapn(y, 18); z = wrapn(z, 16);
        end
        xo = x; yo = y; zo = z;
    endfunction

    // Sends one sample into an idle engine and waits for its result.
    task automatic run_one(input bit mode, input int x, input int y, input int z,
                           output int rx, output int ry, output int rz, output bit rmode,
                           output int lat);
        @(negedge clk);
        s_valid = 1'b1; s_mode = mode;
        s_x = 16'(x); s_y = 16'(y); s_z = 16'(z);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            s_valid = 1'b0;
            if (m_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        rx = int'(m_x); ry = int'(m_y); rz = int'(m_z); rmode = m_mode;
    endtask

    task automatic test_reset;
        reset = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        s_mode = 1'b0; s_x = '0; s_y = '0; s_z = '0;
        #3;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b expected 0", m_valid); else n_pass++;
        n_checks++; if (m_x !== 18'sd0) $display("FAIL rst_m_x: got %0d expected 0", m_x); else n_pass++;
        n_checks++; if (m_y !== 18'sd0) $display("FAIL rst_m_y: got %0d expected 0", m_y); else n_pass++;
        n_checks++; if (m_z !== 16'sd0) $display("FAIL rst_m_z: got %0d expected 0", m_z); else n_pass++;
        n_checks++; if (m_mode !== 1'b0) $display("FAIL rst_m_mode: got %b expected 0", m_mode); else n_pass++;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL rst_s_ready: got %b expected 1", s_ready); else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (s_ready !== 1'b1 || m_valid !== 1'b0)
            $display("FAIL post_rst_idle: got s_ready=%b m_valid=%b expected 1/0", s_ready, m_valid);
        else n_pass++;
    endtask

    task automatic test_vectoring;
        int rx, ry, rz, lat;
        bit rm;
        run_one(1'b0, 10000, 0, 0, rx, ry, rz, rm, lat);
        n_checks++; if (lat !== 16) $display("FAIL vec_latency: got %0d expected 16", lat); else n_pass++;
        n_checks++; if (iabs(rx - 16468) > 4) $display("FAIL vec0_x: got %0d expected 16468+/-4", rx); else n_pass++;
        n_checks++; if (iabs(ry) > 4) $display("FAIL vec0_y: got %0d expected 0+/-4", ry); else n_pass++;
        n_checks++; if (iabs(wrapn(rz, 16)) > 3) $display("FAIL vec0_z: got %0d expected 0+/-3", rz); else n_pass++;
        n_checks++; if (rm !== 1'b0) $display("FAIL vec0_mode: got %b expected 0", rm); else n_pass++;

        run_one(1'b0, 0, 10000, 0, rx, ry, rz, rm, lat);
        n_checks++; if (iabs(wrapn(rz - 16384, 16)) > 3) $display("FAIL vec90_z: got %0d expected 16384+/-3", rz); else n_pass++;
        n_checks++; if (iabs(rx - 16468) > 4) $display("FAIL vec90_x: got %0d expected 16468+/-4", rx); else n_pass++;

        run_one(1'b0, -10000, -1, 0, rx, ry, rz, rm, lat);
        n_checks++; if (iabs(wrapn(rz + 32768, 16)) > 3) $display("FAIL vec180_z: got %0d expected -32768+/-3 (wrapping)", rz); else n_pass++;
    endtask

    task automatic test_rotation;
        int rx, ry, rz, lat;
        bit rm;
        run_one(1'b1, 10000, 0, 8192, rx, ry, rz, rm, lat);
        n_checks++; if (lat !== 16) $display("FAIL rot_latency: got %0d expected 16", lat); else n_pass++;
        n_checks++; if (iabs(rx - 11645) > 4) $display("FAIL rot45_x: got %0d expected 11645+/-4", rx); else n_pass++;
        n_checks++; if (iabs(ry - 11645) > 4) $display("FAIL rot45_y: got %0d expected 11645+/-4", ry); else n_pass++;
        n_checks++; if (iabs(wrapn(rz, 16)) > 3) $display("FAIL rot45_z: got %0d expected 0+/-3", rz); else n_pass++;
        n_checks++; if (rm !== 1'b1) $display("FAIL rot45_mode: got %b expected 1", rm); else n_pass++;

        run_one(1'b1, 10000, 0, -16384, rx, ry, rz, rm, lat);
        n_checks++; if (iabs(rx) > 4) $display("FAIL rotm90_x: got %0d expected 0+/-4", rx); else n_pass++;
        n_checks++; if (iabs(ry + 16468) > 4) $display("FAIL rotm90_y: got %0d expected -16468+/-4", ry); else n_pass++;
    endtask

    task automatic test_back_to_back;
        exp_t q[$];
        exp_t e;
        int sent, got;
        bit md [40];
        int xs [40], ys [40], zs [40];
        logic signed [17:0] hx, hy;
        logic signed [15:0] hz;
        logic hm;
        for (int i = 0; i < 40; i++) begin
            md[i] = 1'($urandom_range(0, 1));
            xs[i] = int'($urandom_range(0, 65535)) - 32768;
            ys[i] = int'($urandom_range(0, 65535)) - 32768;
            zs[i] = int'($urandom_range(0, 65535)) - 32768;
        end
        sent = 0; got = 0;
        hx = '0; hy = '0; hz = '0; hm = 1'b0;
        for (int cyc = 0; cyc < 300 && got < 40; cyc++) begin
            @(negedge clk);
            m_ready = !(cyc >= 25 && cyc < 30);
            if (sent < 40) begin
                s_valid = 1'b1; s_mode = md[sent];
                s_x = 16'(xs[sent]); s_y = 16'(ys[sent]); s_z = 16'(zs[sent]);
            end else begin
                s_valid = 1'b0;
            end
            #1;
            if (cyc == 25) begin
                hx = m_x; hy = m_y; hz = m_z; hm = m_mode;
            end
            if (cyc >= 25 && cyc < 30) begin
                n_checks++; if (s_ready !== 1'b0) $display("FAIL stall_s_ready cyc %0d: got %b expected 0", cyc, s_ready); else n_pass++;
            end
            if (cyc > 25 && cyc < 30) begin
                n_checks++;
                if ({m_valid, m_x, m_y, m_z, m_mode} !== {1'b1, hx, hy, hz, hm})
                    $display("FAIL stall_hold cyc %0d: got v=%b x=%0d y=%0d z=%0d m=%b expected v=1 x=%0d y=%0d z=%0d m=%b",
                             cyc, m_valid, m_x, m_y, m_z, m_mode, hx, hy, hz, hm);
                else n_pass++;
            end
            if (s_valid && s_ready) begin
                model(md[sent], xs[sent], ys[sent], zs[sent], e.x, e.y, e.z);
                e.mode = md[sent];
                q.push_back(e);
                sent++;
            end
            if (m_valid === 1'b1 && m_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL b2b_extra: got unexpected result x=%0d expected none", m_x);
                end else begin
                    e = q.pop_front();
                    if (int'(m_x) !== e.x || int'(m_y) !== e.y || int'(m_z) !== e.z || m_mode !== e.mode)
                        $display("FAIL b2b_result %0d: got x=%0d y=%0d z=%0d m=%b expected x=%0d y=%0d z=%0d m=%b",
                                 got, m_x, m_y, m_z, m_mode, e.x, e.y, e.z, e.mode);
                    else n_pass++;
                end
                got++;
            end
        end
        @(negedge clk);
        s_valid = 1'b0; m_ready = 1'b1;
        n_checks++; if (got !== 40 || sent !== 40) $display("FAIL b2b_count: got %0d results of %0d sent expected 40", got, sent); else n_pass++;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_in_flight;
        int rx, ry, rz, lat, ex, ey, ez, zin;
        bit rm, seen;
        m_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            s_valid = 1'b1; s_mode = 1'($urandom_range(0, 1));
            s_x = 16'($urandom); s_y = 16'($urandom); s_z = 16'($urandom);
        end
        @(negedge clk);
        s_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (m_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL flight_m_valid: got %b expected 1 before reset", seen); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL async_rst_m_valid: got %b expected 0", m_valid); else n_pass++;
        n_checks++; if ({m_x, m_y, m_z, m_mode} !== '0)
            $display("FAIL async_rst_data: got x=%0d y=%0d z=%0d m=%b expected 0", m_x, m_y, m_z, m_mode);
        else n_pass++;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL async_rst_s_ready: got %b expected 1", s_ready); else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (m_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL ghost_output: got m_valid after reset expected none"); else n_pass++;
        zin = int'($urandom_range(0, 65535)) - 32768;
        model(1'b1, 7000, -3000, zin, ex, ey, ez);
        run_one(1'b1, 7000, -3000, zin, rx, ry, rz, rm, lat);
        n_checks++; if (lat !== 16) $display("FAIL post_rst_latency: got %0d expected 16", lat); else n_pass++;
        n_checks++; if (rx !== ex || ry !== ey || rz !== ez)
            $display("FAIL post_rst_result: got x=%0d y=%0d z=%0d expected x=%0d y=%0d z=%0d", rx, ry, rz, ex, ey, ez);
        else n_pass++;
    endtask

    initial begin
        real xr;
        for (int i = 0; i < NSTG; i++) begin
            xr = 1.0;
            for (int k = 0; k < i; k++) xr = xr / 2.0;
            atan_tab[i] = $rtoi($atan(xr) * 65536.0 / (2.0 * 3.14159265358979323846) + 0.5);
        end
        test_reset();
        test_vectoring();
        test_rotation();
        test_back_to_back();
        test_reset_in_flight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cordic_engine.md
CORDIC_ENGINE -- requirements
Module: cordic_engine

Interface
REQ-001 Parameter DATA_W, default 16: signed width of s_x and s_y.
REQ-002 Parameter ANGLE_W, default 16: signed binary-angle width; full scale 2^ANGLE_W = 360 deg.
REQ-003 Parameter STAGES, default 14: micro-rotation count; legal range 4..ANGLE_W-1, otherwise elaboration error.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 s_valid  in  1  input sample valid.
REQ-007 s_ready  out  1  engine accepts a sample this cycle.
REQ-008 s_mode  in  1  0 = vectoring, 1 = rotation.
REQ-009 s_x, s_y  in  DATA_W  signed input vector.
REQ-010 s_z  in  ANGLE_W  signed input angle.
REQ-011 m_valid  out  1  result valid.
REQ-012 m_ready  in  1  downstream accepts the result.
REQ-013 m_x, m_y  out  DATA_W+2  signed result vector, not gain-compensated.
REQ-014 m_z  out  ANGLE_W  signed result angle.
REQ-015 m_mode  out  1  s_mode carried with the sample.

Function
REQ-016 Transfer occurs on s_valid&&s_ready (input) and on m_valid&&m_ready (output).
REQ-017 Global advance en = !m_valid || m_ready; s_ready = en (combinational); the whole pipeline holds when en=0.
REQ-018 Pipeline = 1 pre-rotation register, then STAGES micro-rotation registers, then 1 output register; latency STAGES+2 cycles from accept to m_valid with no stall.
REQ-019 A valid bit travels with each sample; bubbles are not collapsed; results leave in input order; no sample is dropped or duplicated.
REQ-020 Internal x/y width DATA_W+2, sign-extended at input; z width ANGLE_W; all z arithmetic wraps modulo 2^ANGLE_W.
REQ-021 Pre-rotation, vectoring: if y>=0 then x'=y, y'=-x, z'=z+2^(ANGLE_W-2); else x'=-y, y'=x, z'=z-2^(ANGLE_W-2).
REQ-022 Pre-rotation, rotation: if z>=0 then x'=-y, y'=x, z'=z-2^(ANGLE_W-2); else x'=y, y'=-x, z'=z+2^(ANGLE_W-2).
REQ-023 Micro-rotation stage i (0..STAGES-1) computes x'=x-d*(y>>>i), y'=y+d*(x>>>i), z'=z-d*A[i]. Shifts are arithmetic. Sums are truncated to the internal width.
REQ-024 Direction d: vectoring d=+1 if y<0, else -1; rotation d=+1 if z>=0, else -1; mode is per-sample, taken from the carried s_mode.
REQ-025 A[i] = round(atan(2^-i)*2^ANGLE_W/(2*pi)) is computed at elaboration (A[0]=8192 for ANGLE_W=16).
REQ-026 Outputs: vectoring m_x≈G*|v|, m_y≈0, m_z≈s_z+angle(v); rotation (m_x,m_y)≈G*rotate(v,s_z), m_z≈0; G≈1.6468.
REQ-027 Output register loads only when en=1; m_x/m_y/m_z/m_mode are stable while m_valid=1 and m_ready=0.
REQ-028 Mode switch between consecutive samples takes effect per sample with no flush or bubble.

Reset
REQ-029 While reset=1: every valid bit, m_valid, m_x, m_y, m_z and m_mode equal 0 immediately (asynchronous), independent of clk.
REQ-030 Datapath registers other than the outputs need no reset; no result from a sample accepted before reset appears after reset deasserts.
REQ-031 s_ready=1 during and after reset, since m_valid=0.

Verification (DATA_W=16, ANGLE_W=16, STAGES=14; tolerance ±4 LSB on x/y, ±3 LSB on z)
REQ-032 Vectoring (10000, 0, 0) -> m_x≈16468, m_y≈0, m_z≈0, m_valid 16 cycles after accept.
REQ-033 Vectoring (0, 10000, 0) -> m_z≈16384; vectoring (-10000, -1, 0) -> m_z≈-32768 (wrap accepted as ±32767).
REQ-034 Rotation (10000, 0, 8192) -> m_x≈11645, m_y≈11645, m_z≈0; rotation (10000, 0, -16384) -> m_x≈0, m_y≈-16468.
REQ-035 Back-to-back stream of 40 random mixed-mode samples with m_ready low for 5 cycles mid-stream -> s_ready low while stalled, outputs held stable, all 40 results in order and matching the reference model.
REQ-036 Reset asserted between clock edges with 10 samples in flight -> m_valid falls immediately; after release, no output until a new sample is accepted, whose result follows 16 cycles later.
